// File: rtl/t_stream_decoder_pkg.sv
// Shared definitions for the T flip-flop toggle-stream decoder and the
// encoder-side T_FF benches.
package t_stream_decoder_pkg;

  localparam int unsigned WIDTH_DEF  = 8;
  localparam int unsigned CNT_W      = $clog2(WIDTH_DEF);
  localparam logic        INIT_Q_DEF = 1'b0;

  // Inverse of q[n+1] = q[n] ^ t[n]
  function automatic logic t_decode(input logic q, input logic prev);
    return q ^ prev;
  endfunction

endpackage

// File: rtl/t_ff_decode.sv
// One-bit inverse T flip-flop: remembers the previous level and recovers
// the toggle bit as the XOR of the current and previous levels.
module t_ff_decode
  import t_stream_decoder_pkg::*;
#(
  parameter logic INIT_Q = INIT_Q_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  input  logic q_in,
  output logic t_bit
);

  logic prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      prev_q <= INIT_Q;
    end else if (en) begin
      prev_q <= q_in;
    end
  end

  assign t_bit = t_decode(q_in, prev_q);

endmodule

// File: rtl/t_stream_decoder.sv
// Toggle-stream decoder: recovers t bits, deserialises them LSB-first and
// offers each word through a one-entry valid/ready holding register.
module t_stream_decoder
  import t_stream_decoder_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_DEF,
  parameter logic        INIT_Q = INIT_Q_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     q_in,
  input  logic                     q_valid,
  input  logic                     clr,
  output logic [WIDTH-1:0]         t_word,
  output logic                     t_valid,
  input  logic                     t_ready,
  output logic                     overrun,
  output logic [$clog2(WIDTH)-1:0] bit_cnt
);

  localparam int unsigned    BW   = $clog2(WIDTH);
  localparam logic [BW-1:0]  LAST = BW'(WIDTH - 1);

  logic [WIDTH-1:0] shift;
  logic [WIDTH-1:0] word;
  logic             t_bit;
  logic             sample;
  logic             done;
  logic             load;

  assign sample = q_valid && !clr;

  t_ff_decode #(
    .INIT_Q(INIT_Q)
  ) u_dec (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (sample),
    .clr   (clr),
    .q_in  (q_in),
    .t_bit (t_bit)
  );

  // The held slot frees up in the same cycle it is consumed, so a completing
  // word may replace it without a bubble.
  always_comb begin
    word = {t_bit, shift[WIDTH-1:1]};
    done = sample && (bit_cnt == LAST);
    load = done && (!t_valid || t_ready);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift   <= '0;
      bit_cnt <= '0;
      t_word  <= '0;
      t_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (clr) begin
        shift   <= '0;
        bit_cnt <= '0;
      end else if (q_valid) begin
        shift   <= word;
        bit_cnt <= done ? '0 : bit_cnt + BW'(1);
      end

      if (load) begin
        t_word  <= word;
        t_valid <= 1'b1;
      end else if (t_valid && t_ready) begin
        t_valid <= 1'b0;
      end

      if (clr) begin
        overrun <= 1'b0;
      end else if (done && !load) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_t_stream_decoder.sv
// Self-checking bench for t_stream_decoder: directed scenarios plus a
// randomized run against a word-level reference model.
module tb_t_stream_decoder;
  import t_stream_decoder_pkg::*;

  logic             clk;
  logic             rst_n;
  logic             q_in;
  logic             q_valid;
  logic             clr;
  logic [7:0]       t_word;
  logic             t_valid;
  logic             t_ready;
  logic             overrun;
  logic [CNT_W-1:0] bit_cnt;

  int vectors;
  int miscompares;

  // reference model state
  logic       m_prev;
  int         m_bits;
  logic [7:0] m_acc;
  logic [7:0] m_word;
  logic       m_valid;
  logic       m_ovr;
  logic       enc_q;

  t_stream_decoder #(
    .WIDTH  (8),
    .INIT_Q (1'b0)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .q_in    (q_in),
    .q_valid (q_valid),
    .clr     (clr),
    .t_word  (t_word),
    .t_valid (t_valid),
    .t_ready (t_ready),
    .overrun (overrun),
    .bit_cnt (bit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_step(input logic q, input logic qv, input logic c,
                            input logic rdy, input logic rn);
    logic       b;
    logic       done;
    logic [7:0] w;
    logic       hs;
    done = 1'b0;
    w    = 8'h00;
    hs   = m_valid && rdy;
    if (!rn) begin
      m_prev = 1'b0; m_bits = 0; m_acc = 8'h00;
      m_word = 8'h00; m_valid = 1'b0; m_ovr = 1'b0;
    end else begin
      if (c) begin
        m_bits = 0; m_acc = 8'h00; m_prev = 1'b0; m_ovr = 1'b0;
      end else if (qv) begin
        b = q ^ m_prev;
        m_prev = q;
        m_acc = m_acc | (8'(b) << m_bits);
        m_bits = m_bits + 1;
        if (m_bits == 8) begin
          done = 1'b1; w = m_acc; m_bits = 0; m_acc = 8'h00;
        end
      end
      if (done) begin
        if (!m_valid || rdy) begin
          m_word = w; m_valid = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (hs) begin
        m_valid = 1'b0;
      end
    end
  endtask

  // Apply one cycle of inputs; outputs are settled #1 after the edge.
  task automatic drive(input logic q, input logic qv, input logic c,
                       input logic rdy, input logic rn);
    q_in = q; q_valid = qv; clr = c; t_ready = rdy; rst_n = rn;
    @(posedge clk);
    model_step(q, qv, c, rdy, rn);
    if (!rn || c) enc_q = 1'b0;
    #1;
  endtask

  task automatic send_word(input logic [7:0] w, input int maxgap, input logic rdy);
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, maxgap)) drive(enc_q, 1'b0, 1'b0, rdy, 1'b1);
      enc_q = enc_q ^ w[i];
      drive(enc_q, 1'b1, 1'b0, rdy, 1'b1);
    end
  endtask

  task automatic test_reset;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if ({t_word, t_valid, overrun, bit_cnt} !== 13'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got word=%h v=%b ovr=%b cnt=%0d want all 0",
               t_word, t_valid, overrun, bit_cnt);
    end
  endtask

  task automatic test_basic;
    send_word(8'hA5, 0, 1'b1);
    vectors++;
    if (t_valid !== 1'b1 || t_word !== 8'hA5) begin
      miscompares++;
      $display("FAIL basic_word: got v=%b word=%h want v=1 word=a5", t_valid, t_word);
    end
    vectors++;
    if (bit_cnt !== 3'd0) begin
      miscompares++;
      $display("FAIL basic_cnt: got %0d want 0", bit_cnt);
    end
    drive(enc_q, 1'b0, 1'b0, 1'b1, 1'b1);
    vectors++;
    if (t_valid !== 1'b0 || t_word !== 8'hA5) begin
      miscompares++;
      $display("FAIL basic_pulse: got v=%b word=%h want v=0 word=a5", t_valid, t_word);
    end
  endtask

  task automatic test_gaps;
    logic [7:0] w;
    w = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 3)) begin
        drive(enc_q, 1'b0, 1'b0, 1'b1, 1'b1);
        vectors++;
        if (bit_cnt !== 3'(i)) begin
          miscompares++;
          $display("FAIL gaps_cnt_hold: got %0d want %0d", bit_cnt, i);
        end
      end
      enc_q = enc_q ^ w[i];
      drive(enc_q, 1'b1, 1'b0, 1'b1, 1'b1);
      vectors++;
      if (bit_cnt !== 3'((i + 1) % 8)) begin
        miscompares++;
        $display("FAIL gaps_cnt_step: got %0d want %0d", bit_cnt, (i + 1) % 8);
      end
    end
    vectors++;
    if (t_valid !== 1'b1 || t_word !== 8'hA5) begin
      miscompares++;
      $display("FAIL gaps_word: got v=%b word=%h want v=1 word=a5", t_valid, t_word);
    end
    drive(enc_q, 1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_overrun;
    send_word(8'hA5, 0, 1'b0);
    send_word(8'h3C, 0, 1'b0);
    vectors++;
    if (t_word !== 8'hA5 || t_valid !== 1'b1 || overrun !== 1'b1) begin
      miscompares++;
      $display("FAIL overrun_hold: got word=%h v=%b ovr=%b want a5 1 1", t_word, t_valid, overrun);
    end
    drive(enc_q, 1'b0, 1'b0, 1'b1, 1'b1);
    vectors++;
    if (t_valid !== 1'b0 || overrun !== 1'b1) begin
      miscompares++;
      $display("FAIL overrun_sticky: got v=%b ovr=%b want 0 1", t_valid, overrun);
    end
    drive(enc_q, 1'b0, 1'b1, 1'b1, 1'b1);
    vectors++;
    if (overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL overrun_clr: got %b want 0", overrun);
    end
  endtask

  task automatic test_clr;
    for (int i = 0; i < 3; i++) drive(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    vectors++;
    if (bit_cnt !== 3'd0) begin
      miscompares++;
      $display("FAIL clr_cnt: got %0d want 0", bit_cnt);
    end
    send_word(8'hFF, 0, 1'b1);
    vectors++;
    if (t_valid !== 1'b1 || t_word !== 8'hFF || overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL clr_word: got v=%b word=%h ovr=%b want 1 ff 0", t_valid, t_word, overrun);
    end
    drive(enc_q, 1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_back_to_back;
    logic [15:0] w;
    logic        exp_v;
    w = 16'hFF00;
    for (int i = 0; i < 16; i++) begin
      enc_q = enc_q ^ w[i];
      drive(enc_q, 1'b1, 1'b0, 1'b1, 1'b1);
      exp_v = (i == 7) || (i == 15);
      vectors++;
      if (t_valid !== exp_v) begin
        miscompares++;
        $display("FAIL b2b_valid[%0d]: got %b want %b", i, t_valid, exp_v);
      end
      if (exp_v) begin
        vectors++;
        if (t_word !== ((i == 7) ? 8'h00 : 8'hFF) || overrun !== 1'b0) begin
          miscompares++;
          $display("FAIL b2b_word[%0d]: got %h ovr=%b want %h ovr=0",
                   i, t_word, overrun, (i == 7) ? 8'h00 : 8'hFF);
        end
      end
    end
    drive(enc_q, 1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 5; i++) begin
      enc_q = enc_q ^ 1'($urandom_range(0, 1));
      drive(enc_q, 1'b1, 1'b0, 1'b1, 1'b1);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    vectors++;
    if ({t_word, t_valid, overrun, bit_cnt} !== 13'h0) begin
      miscompares++;
      $display("FAIL reset_midframe: got word=%h v=%b ovr=%b cnt=%0d want all 0",
               t_word, t_valid, overrun, bit_cnt);
    end
    send_word(8'h5A, 0, 1'b0);
    drive(enc_q, 1'b0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if ({t_word, t_valid, overrun, bit_cnt} !== 13'h0) begin
      miscompares++;
      $display("FAIL reset_midhold: got word=%h v=%b ovr=%b cnt=%0d want all 0",
               t_word, t_valid, overrun, bit_cnt);
    end
    send_word(8'hA5, 0, 1'b1);
    vectors++;
    if (t_valid !== 1'b1 || t_word !== 8'hA5) begin
      miscompares++;
      $display("FAIL reset_redecode: got v=%b word=%h want 1 a5", t_valid, t_word);
    end
    drive(enc_q, 1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_random;
    logic q, qv, c, rdy, rn;
    for (int i = 0; i < 400; i++) begin
      q   = 1'($urandom_range(0, 1));
      qv  = ($urandom_range(0, 3) != 0);
      c   = ($urandom_range(0, 39) == 0);
      rdy = ($urandom_range(0, 2) == 0);
      rn  = ($urandom_range(0, 149) != 0);
      drive(q, qv, c, rdy, rn);
      vectors++;
      if (t_valid !== m_valid || overrun !== m_ovr ||
          t_word !== m_word || bit_cnt !== 3'(m_bits)) begin
        miscompares++;
        $display("FAIL random[%0d]: got v=%b ovr=%b word=%h cnt=%0d want v=%b ovr=%b word=%h cnt=%0d",
                 i, t_valid, overrun, t_word, bit_cnt, m_valid, m_ovr, m_word, m_bits);
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    enc_q = 1'b0;
    rst_n = 1'b0; q_in = 1'b0; q_valid = 1'b0; clr = 1'b0; t_ready = 1'b0;
    model_step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    test_reset;
    test_basic;
    test_gaps;
    test_overrun;
    test_clr;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
